// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the LCD command engine: FSM states, store-word
// field positions, long-command codes and default HD44780-style timings.
package lcd_pkg;

    localparam int unsigned CNT_W    = 20;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ON_BIT   = 31;
    localparam int unsigned RS_BIT   = 8;
    localparam int unsigned DATA_LSB = 0;

    localparam int unsigned DEF_SETUP_CYC = 2;
    localparam int unsigned DEF_PULSE_CYC = 12;
    localparam int unsigned DEF_HOLD_CYC  = 2;
    localparam int unsigned DEF_EXEC_CYC  = 2000;
    localparam int unsigned DEF_LONG_CYC  = 82000;
    localparam int unsigned DEF_PWR_CYC   = 750000;

    localparam logic [DATA_W-1:0] CMD_CLEAR    = 8'h01;
    localparam logic [DATA_W-1:0] CMD_HOME     = 8'h02;
    localparam logic [DATA_W-1:0] CMD_HOME_ALT = 8'h03;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } state_e;

    typedef struct packed {
        logic              rs;
        logic [DATA_W-1:0] data;
    } lcd_cmd_t;

    // Clear and return-home instructions need the long execution wait.
    function automatic logic is_long_cmd(input lcd_cmd_t cmd);
        return !cmd.rs && (cmd.data == CMD_CLEAR || cmd.data == CMD_HOME ||
                           cmd.data == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Interfaces for the LCD engine: the timer load/zero handshake and the
// software-facing register/LCD pin bundle.
interface lcd_tmr_if;
    import lcd_pkg::*;

    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             zero_c;

    modport master (output load, output load_val, input zero_c);
    modport slave  (input load, input load_val, output zero_c);
endinterface

interface lcd_bus_if;
    logic        wr;
    logic [31:0] wdata;
    logic        busy;
    logic        overrun;
    logic        lcd_on;
    logic        lcd_en;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    modport master (output wr, output wdata, input busy, input overrun,
                    input lcd_on, input lcd_en, input lcd_rs, input lcd_rw, input lcd_data);
    modport slave  (input wr, input wdata, output busy, output overrun,
                    output lcd_on, output lcd_en, output lcd_rs, output lcd_rw, output lcd_data);
endinterface

// File: rtl/lcd_ctrl_timer.sv
// Loadable down-counter that holds at zero and flags it; reset value is the
// power-up wait so the engine starts counting straight out of reset.
module lcd_timer
    import lcd_pkg::*;
#(
    parameter int unsigned RST_VAL = 0
) (
    input  logic       clk,
    input  logic       rst,
    lcd_tmr_if.slave   tmr
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (tmr.load) begin
            cnt_d = tmr.load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmr.zero_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Write-only LCD command engine: sequences setup/EN-pulse/hold/execute timing
// for each store, with a one-entry pending slot and a sticky overrun flag.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
    parameter int unsigned EXEC_CYC  = DEF_EXEC_CYC,
    parameter int unsigned LONG_CYC  = DEF_LONG_CYC,
    parameter int unsigned PWR_CYC   = DEF_PWR_CYC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);

    state_e   state_q, state_d;
    lcd_cmd_t cmd_q, cmd_d;
    lcd_cmd_t slot_q, slot_d;
    logic     slot_vld_q, slot_vld_d;
    logic     on_q, on_d;
    logic     ovr_q, ovr_d;
    logic     busy_q, busy_d;
    logic     en_q, en_d;

    lcd_cmd_t wr_cmd;
    logic     wr_on;
    logic     go_slot;
    logic     launch;

    logic     unused_wdata;
    assign unused_wdata = ^i_wdata[30:9];

    lcd_tmr_if tmr ();

    lcd_timer #(.RST_VAL(PWR_CYC - 1)) u_timer (
        .clk (i_clk),
        .rst (i_rst),
        .tmr (tmr.slave)
    );

    always_comb begin
        wr_cmd.rs   = i_wdata[RS_BIT];
        wr_cmd.data = i_wdata[DATA_LSB +: DATA_W];
        wr_on       = i_wdata[ON_BIT];
    end

    // Next-state, slot bookkeeping and timer loads.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        slot_d       = slot_q;
        slot_vld_d   = slot_vld_q;
        on_d         = on_q;
        ovr_d        = ovr_q;
        go_slot      = 1'b0;
        launch       = 1'b0;
        tmr.load     = 1'b0;
        tmr.load_val = '0;

        case (state_q)
            ST_PWRUP, ST_EXEC: begin
                if (tmr.zero_c) begin
                    if (slot_vld_q) go_slot = 1'b1;
                    else            state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // A write that landed in the slot on the PWRUP exit is started here.
                if (slot_vld_q)  go_slot = 1'b1;
                else if (i_wr)   launch  = 1'b1;
            end
            ST_SETUP: begin
                if (tmr.zero_c) begin
                    state_d      = ST_PULSE;
                    tmr.load     = 1'b1;
                    tmr.load_val = CNT_W'(PULSE_CYC - 1);
                end
            end
            ST_PULSE: begin
                if (tmr.zero_c) begin
                    state_d      = ST_HOLD;
                    tmr.load     = 1'b1;
                    tmr.load_val = CNT_W'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (tmr.zero_c) begin
                    state_d      = ST_EXEC;
                    tmr.load     = 1'b1;
                    tmr.load_val = is_long_cmd(cmd_q) ? CNT_W'(LONG_CYC - 1)
                                                      : CNT_W'(EXEC_CYC - 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_slot || launch) begin
            state_d      = ST_SETUP;
            cmd_d        = go_slot ? slot_q : wr_cmd;
            tmr.load     = 1'b1;
            tmr.load_val = CNT_W'(SETUP_CYC - 1);
        end

        if (go_slot) slot_vld_d = 1'b0;

        if (i_wr) begin
            if (launch) begin
                on_d = wr_on;
            end else if (!slot_vld_q || go_slot) begin
                slot_d     = wr_cmd;
                slot_vld_d = 1'b1;
                on_d       = wr_on;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE) || slot_vld_d;
        en_d   = (state_d == ST_PULSE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_PWRUP;
            cmd_q      <= '0;
            slot_q     <= '0;
            slot_vld_q <= 1'b0;
            on_q       <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b1;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            slot_q     <= slot_d;
            slot_vld_q <= slot_vld_d;
            on_q       <= on_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
            en_q       <= en_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_overrun  = ovr_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_rs   = cmd_q.rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = cmd_q.data;

endmodule
